// File: rtl/sda_action_stub_regfile.sv
// sda_action_stub_regfile: action stub with param fetch, completion delay and AXI-lite register file
module sda_action_stub_regfile #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned NUM_PARAMS = 2,
  parameter int unsigned PARAM_BASE = 0,
  parameter int unsigned DONE_DELAY = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go_0r,
  output logic        go_0a,
  output logic        done_0r,
  input  logic        done_0a,
  output logic        param_addr_0r,
  output logic [31:0] param_addr,
  input  logic        param_addr_0a,
  input  logic        param_data_0r,
  input  logic [31:0] param_data,
  output logic        param_data_0a,
  input  logic [31:0] s_axi_araddr,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [3:0]  s_axi_awcache,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, ACK, GAP, DELAY, DONE} state_t;
  state_t state, state_next;
  logic        armed, busy, last, wr_ok;
  logic [31:0] idx, ra, wa, rd_data;
  logic [1:0]  rd_resp;
  logic [15:0] dly, done_count;
  logic [31:0] scratch [NUM_REGS];
  logic [31:0] shadow [NUM_PARAMS];
  logic        unused;
  assign unused = ^{s_axi_arcache, s_axi_arprot, s_axi_awcache, s_axi_awprot,
                    s_axi_araddr[1:0], s_axi_awaddr[1:0]};
  assign last  = idx == NUM_PARAMS - 1;
  assign ra    = {2'b00, s_axi_araddr[31:2]};
  assign wa    = {2'b00, s_axi_awaddr[31:2]};
  assign wr_ok = wa < NUM_REGS;
  assign s_axi_wready = s_axi_awready;
  // action state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  // action next-state; FETCH is split into address, data, ack and inter-word gap phases
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go_0r && armed) state_next = ADDR;
      ADDR:    if (param_addr_0a) state_next = DATA;
      DATA:    if (param_data_0r) state_next = ACK;
      ACK:     if (!param_data_0r) state_next = last ? DELAY : GAP;
      GAP:     if (!param_addr_0a) state_next = ADDR;
      DELAY:   if (dly <= 16'd1) state_next = DONE;
      DONE:    if (done_0a) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    param_addr_0r = state == ADDR;
    param_addr    = param_addr_0r ? PARAM_BASE + (idx << 2) : '0;
    param_data_0a = state == ACK;
    done_0r       = state == DONE;
    go_0a         = done_0r;
    busy          = state inside {ADDR, DATA, ACK, GAP, DELAY};
  end
  // word index, delay counter, parameter shadows, completion count and re-arm flag
  always_ff @(posedge clk) begin
    if (reset) begin
      armed      <= 1'b1;
      idx        <= '0;
      dly        <= '0;
      done_count <= '0;
      for (int k = 0; k < NUM_PARAMS; k++) shadow[k] <= '0;
    end else begin
      armed      <= (state == DONE && done_0a) ? 1'b0 : !go_0r ? 1'b1 : armed;
      idx        <= state == IDLE ? '0 : (state == ACK && !param_data_0r) ? idx + 1 : idx;
      dly        <= state == DELAY ? dly - 16'd1 : 16'(DONE_DELAY);
      done_count <= (state == DONE && done_0a) ? done_count + 16'd1 : done_count;
      for (int k = 0; k < NUM_PARAMS; k++)
        if (state == DATA && param_data_0r && idx == k) shadow[k] <= param_data;
    end
  end
  // read decode: scratch, status, then shadows; anything else is a slave error
  always_comb begin
    rd_data = '0;
    rd_resp = 2'b10;
    for (int k = 0; k < NUM_REGS; k++)
      if (ra == k) begin
        rd_data = scratch[k];
        rd_resp = 2'b00;
      end
    if (ra == NUM_REGS) begin
      rd_data = {done_count, 14'd0, state == DONE, busy};
      rd_resp = 2'b00;
    end
    for (int k = 0; k < NUM_PARAMS; k++)
      if (ra == NUM_REGS + 1 + k) begin
        rd_data = shadow[k];
        rd_resp = 2'b00;
      end
  end
  // read channel: one-cycle arready accept, data latched on the accept edge, held until rready
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
    end else begin
      s_axi_arready <= s_axi_arvalid && !s_axi_arready && !s_axi_rvalid;
      if (s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
    end
  end
  // write channel: joint aw/w accept, byte-strobed scratch commit on the accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_awready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      for (int k = 0; k < NUM_REGS; k++) scratch[k] <= '0;
    end else begin
      s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_awready && !s_axi_bvalid;
      if (s_axi_awready) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_ok ? 2'b00 : 2'b10;
      end else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++)
        for (int b = 0; b < 4; b++)
          if (s_axi_awready && wa == k && s_axi_wstrb[b])
            scratch[k][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_sda_action_stub_regfile.sv
// tb_sda_action_stub_regfile: directed self-checking bench for the action stub register file
module tb_sda_action_stub_regfile;
  logic        clk, reset;
  logic        go_0r, go_0a, done_0r, done_0a;
  logic        param_addr_0r, param_addr_0a, param_data_0r, param_data_0a;
  logic [31:0] param_addr, param_data;
  logic [31:0] s_axi_araddr, s_axi_rdata, s_axi_awaddr, s_axi_wdata;
  logic [3:0]  s_axi_arcache, s_axi_awcache, s_axi_wstrb;
  logic [2:0]  s_axi_arprot, s_axi_awprot;
  logic        s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_rresp, s_axi_bresp;
  int          checks, failures, n;
  logic [31:0] d;
  logic [1:0]  r;

  sda_action_stub_regfile dut (
    .clk(clk), .reset(reset),
    .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
    .param_addr_0r(param_addr_0r), .param_addr(param_addr), .param_addr_0a(param_addr_0a),
    .param_data_0r(param_data_0r), .param_data(param_data), .param_data_0a(param_data_0a),
    .s_axi_araddr(s_axi_araddr), .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
    int k;
    @(negedge clk);
    s_axi_araddr = a;
    s_axi_arvalid = 1'b1;
    k = 0;
    while (!s_axi_arready && k < 20) begin @(negedge clk); k++; end
    check("arready", s_axi_arready, 1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    check("rvalid", s_axi_rvalid, 1);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    int k;
    @(negedge clk);
    s_axi_awaddr = a;
    s_axi_wdata = data;
    s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1;
    k = 0;
    while (!s_axi_awready && k < 20) begin @(negedge clk); k++; end
    check("awready", s_axi_awready, 1);
    check("wready", s_axi_wready, 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    check("bvalid", s_axi_bvalid, 1);
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic fetch_word(input logic [31:0] a, input logic [31:0] data);
    int k;
    k = 0;
    while (!param_addr_0r && k < 50) begin @(negedge clk); k++; end
    check("paddr_req", param_addr_0r, 1);
    check("paddr", param_addr, a);
    @(negedge clk);
    check("paddr_hold_req", param_addr_0r, 1);
    check("paddr_hold", param_addr, a);
    param_addr_0a = 1'b1;
    @(negedge clk);
    check("paddr_drop", param_addr_0r, 0);
    param_addr_0a = 1'b0;
    param_data_0r = 1'b1;
    param_data = data;
    @(negedge clk);
    check("pdata_ack", param_data_0a, 1);
    param_data_0r = 1'b0;
    @(negedge clk);
    check("pdata_ack_drop", param_data_0a, 0);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done_0r && cycles < 50) begin @(negedge clk); cycles++; end
    check("done_0r", done_0r, 1);
  endtask

  task automatic finish_done();
    @(negedge clk);
    done_0a = 1'b1;
    @(negedge clk);
    check("done_drop", done_0r, 0);
    check("go_0a_drop", go_0a, 0);
    done_0a = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    {go_0r, done_0a, param_addr_0a, param_data_0r} = '0;
    param_data = '0;
    {s_axi_araddr, s_axi_awaddr, s_axi_wdata} = '0;
    {s_axi_arcache, s_axi_awcache, s_axi_wstrb, s_axi_arprot, s_axi_awprot} = '0;
    {s_axi_arvalid, s_axi_rready, s_axi_awvalid, s_axi_wvalid, s_axi_bready} = '0;
    repeat (3) @(negedge clk);
    check("rst_done", done_0r, 0);
    check("rst_go_0a", go_0a, 0);
    check("rst_paddr_r", param_addr_0r, 0);
    check("rst_pdata_a", param_data_0a, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_awready", s_axi_awready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid", s_axi_rvalid, 0);
    axi_read(32'h10, d, r);
    check("status0", d, 32'h0);
    check("status0_resp", r, 2'b00);

    go_0r = 1'b1;
    fetch_word(32'h0, 32'hA5A5_0001);
    fetch_word(32'h4, 32'hA5A5_0002);
    wait_done(n);
    check("delay_cycles", n, 8);
    check("go_0a", go_0a, 1);
    finish_done();
    repeat (3) begin
      @(negedge clk);
      check("no_rerun", param_addr_0r, 0);
    end
    axi_read(32'h14, d, r);
    check("shadow0", d, 32'hA5A5_0001);
    check("shadow0_resp", r, 2'b00);
    axi_read(32'h18, d, r);
    check("shadow1", d, 32'hA5A5_0002);
    axi_read(32'h10, d, r);
    check("status_cnt1", d, 32'h0001_0000);

    go_0r = 1'b0;
    @(negedge clk);
    go_0r = 1'b1;
    fetch_word(32'h0, 32'h1234_5678);
    fetch_word(32'h4, 32'h9ABC_DEF0);
    wait_done(n);
    check("status_pending", {s_axi_rvalid, done_0r}, 2'b01);
    finish_done();
    go_0r = 1'b0;
    axi_read(32'h10, d, r);
    check("status_cnt2", d, 32'h0002_0000);
    axi_read(32'h18, d, r);
    check("shadow1_new", d, 32'h9ABC_DEF0);

    axi_write(32'h4, 32'hDEAD_BEEF, 4'b0101, r);
    check("wr_bresp", r, 2'b00);
    axi_read(32'h4, d, r);
    check("wr_strobe", d, 32'h00AD_00EF);
    axi_write(32'h0, 32'h0BAD_F00D, 4'b1111, r);
    axi_read(32'h0, d, r);
    check("wr_full", d, 32'h0BAD_F00D);
    axi_write(32'h13, 32'hFFFF_FFFF, 4'b1111, r);
    check("wr_status_bresp", r, 2'b10);
    axi_read(32'h10, d, r);
    check("status_unchanged", d, 32'h0002_0000);
    axi_read(32'h24, d, r);
    check("oor_rdata", d, 32'h0);
    check("oor_rresp", r, 2'b10);

    @(negedge clk);
    s_axi_araddr = 32'h4;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
    check("hold_arready", s_axi_arready, 1);
    @(negedge clk);
    repeat (5) begin
      check("hold_rvalid", s_axi_rvalid, 1);
      check("hold_rdata", s_axi_rdata, 32'h00AD_00EF);
      check("hold_no_accept", s_axi_arready, 0);
      @(negedge clk);
    end
    s_axi_rready = 1'b1;
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    s_axi_rready = 1'b0;
    check("hold_release", s_axi_rvalid, 0);

    force dut.done_count = 16'hFFFF;
    @(negedge clk);
    release dut.done_count;
    go_0r = 1'b1;
    fetch_word(32'h0, 32'h1);
    fetch_word(32'h4, 32'h2);
    wait_done(n);
    finish_done();
    go_0r = 1'b0;
    axi_read(32'h10, d, r);
    check("status_wrap", d, 32'h0);

    @(negedge clk);
    go_0r = 1'b1;
    n = 0;
    while (!param_addr_0r && n < 50) begin @(negedge clk); n++; end
    check("abort_req", param_addr_0r, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_paddr_r", param_addr_0r, 0);
    check("abort_paddr", param_addr, 32'h0);
    check("abort_done", done_0r, 0);
    check("abort_pdata_a", param_data_0a, 0);
    reset = 1'b0;
    fetch_word(32'h0, 32'hC0DE_0001);
    fetch_word(32'h4, 32'hC0DE_0002);
    wait_done(n);
    check("delay_cycles2", n, 8);
    finish_done();
    go_0r = 1'b0;
    axi_read(32'h10, d, r);
    check("status_after_abort", d, 32'h0001_0000);
    axi_read(32'h14, d, r);
    check("shadow0_after_abort", d, 32'hC0DE_0001);
    axi_read(32'h4, d, r);
    check("scratch_cleared", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sda_action_stub_regfile.md
Name: sda_action_stub_regfile

Overview:
- Parametrised successor to the fixed loopback action stub. Sits in the same kernel-action slot, driven by the go/done control path and the host AXI-lite slave bus.
- Adds three things the fixed stub lacks: a real parameter fetch over the SELF param channels, a programmable completion delay, and a byte-writable AXI-lite register file with a status word and read-back of the fetched parameters.
- Has no AXI master interface. Integration ties off gmem outside this block.

Parameters:
- NUM_REGS, 4, number of 32-bit scratch registers (1..64).
- NUM_PARAMS, 2, parameter words fetched per action (1..16).
- PARAM_BASE, 0, byte address of the first parameter word; word i is at PARAM_BASE+4*i.
- DONE_DELAY, 8, cycles spent in DELAY after the fetch completes (0..65535).

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- go_0r  in  1  action start request
- go_0a  out  1  start acknowledge (equals done_0r)
- done_0r  out  1  action complete request
- done_0a  in  1  completion acknowledge
- param_addr_0r  out  1  param address request
- param_addr  out  32  param byte address
- param_addr_0a  in  1  param address acknowledge
- param_data_0r  in  1  param data request
- param_data  in  32  param data
- param_data_0a  out  1  param data acknowledge
- s_axi_araddr/arcache/arprot/arvalid/arready  in/in/in/in/out  32/4/3/1/1  AXI-lite read address
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  AXI-lite read data
- s_axi_awaddr/awcache/awprot/awvalid/awready  in/in/in/in/out  32/4/3/1/1  AXI-lite write address
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  AXI-lite write data
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  AXI-lite write response

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset: all outputs 0. Scratch regs, param shadows and completion count 0. FSM to IDLE, armed.
- Reset mid-operation aborts any fetch, delay or AXI transaction with no completion.
- Action FSM: IDLE -> FETCH -> DELAY -> DONE -> IDLE.
- IDLE: go_0r sampled 1 while armed -> FETCH, index i=0. Armed is cleared on leaving DONE and set again when go_0r is sampled 0.
- FETCH, per word i:
  - Assert param_addr_0r with param_addr=PARAM_BASE+4*i, stable until param_addr_0a is sampled 1; deassert the next cycle.
  - Wait for param_data_0r=1. Capture param_data into shadow[i] and assert param_data_0a. Hold the ack until param_data_0r is sampled 0, then deassert.
  - Next word starts only after param_addr_0a is sampled 0. After word NUM_PARAMS-1 completes -> DELAY.
- DELAY: counter loads DONE_DELAY and decrements each cycle; at 0 -> DONE. DONE_DELAY=0 gives exactly one cycle in DELAY.
- DONE: done_0r=go_0a=1. When done_0a is sampled 1: increment the 16-bit completion count (wraps 65535->0) and go to IDLE. done_0r falls in the same cycle the state leaves DONE.
- Address map: word index w=addr[31:2]; addr[1:0] ignored.
  - w<NUM_REGS: scratch register, read/write.
  - w==NUM_REGS: status, read-only. bit0 busy (FETCH|DELAY), bit1 done pending, [15:2]=0, [31:16] completion count.
  - NUM_REGS+1 <= w <= NUM_REGS+NUM_PARAMS: shadow[w-NUM_REGS-1], read-only.
  - Other w: reads give rdata 0, rresp 2'b10.
- AXI read channel (one outstanding):
  - In idle, arvalid sampled 1 -> arready pulses high 1 cycle, which is the accept cycle; data is latched from the state before that edge.
  - rvalid rises the next cycle and holds, with rdata stable, until rready is sampled 1.
  - No new accept while rvalid=1. rresp 2'b00 for in-map reads.
- AXI write channel (one outstanding):
  - Accepts only when awvalid and wvalid are both sampled 1; awready=wready pulse together for 1 cycle.
  - Scratch write commits on the accept edge; byte k is written iff wstrb[k].
  - bvalid rises the next cycle and holds until bready is sampled 1. bresp 2'b00 for scratch, 2'b10 for any other index (write ignored).
- Read and write channels are independent. A read accepted in the same cycle as a write to the same register returns the pre-write value.
- arcache, arprot, awcache, awprot: ignored.

Test Plan:
- Reset, then read w=NUM_REGS -> rdata 0x00000000, rresp 0. All handshake outputs 0 during and after reset.
- go_0r=1 with a param responder returning 0xA5A5_0001 and 0xA5A5_0002 -> param_addr sequence 0x0, 0x4. Then exactly 8 DELAY cycles, then done_0r=1. Reads of w=5 and w=6 return the two values.
- Write 0xDEADBEEF to w=1 with wstrb=4'b0101, w=1 previously 0 -> reads 0x00AD00EF, bresp 0. Write to w=4 -> bresp 2'b10, status unchanged.
- Read of w=9 -> rdata 0, rresp 2'b10. Hold rready=0 for 5 cycles -> rvalid and rdata stable throughout, arready stays 0 for a second arvalid.
- go_0r held 1 through DONE, then done_0a=1 -> exactly one action and count=1. Deassert go_0r, reassert -> second action and count=2. Preload count to 0xFFFF -> wraps to 0.
- Assert reset during FETCH with param_addr_0r=1 -> next cycle all outputs 0 and FSM idle. A new go runs a full fetch from i=0.
